// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle, MSB chunk first,
// and stops at the first unequal chunk; falls back to the cascade inputs when all chunks match.
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             busy,
    output logic             done,
    output logic             lt_out,
    output logic             eq_out,
    output logic             gt_out
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [2:0]       cas_q, cas_d;   // {lt_in, eq_in, gt_in}
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CHUNK-1:0] a_chunk, b_chunk;

    always_comb begin
        a_chunk = a_q[CHUNK*32'(idx_q) +: CHUNK];
        b_chunk = b_q[CHUNK*32'(idx_q) +: CHUNK];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cas_d   = cas_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d = a;
                    b_d = b;
                    // Flipping both sign bits maps two's complement order onto unsigned order.
                    if (signed_mode) begin
                        a_d[WIDTH-1] = ~a[WIDTH-1];
                        b_d[WIDTH-1] = ~b[WIDTH-1];
                    end
                    cas_d   = {lt_in, eq_in, gt_in};
                    idx_d   = IdxW'(NCHUNK - 1);
                    state_d = StCmp;
                end else begin
                    state_d = StIdle;
                end
            end
            StCmp: begin
                if (a_chunk > b_chunk) begin
                    {lt_d, eq_d, gt_d} = 3'b001;
                    state_d            = StDone;
                end else if (a_chunk < b_chunk) begin
                    {lt_d, eq_d, gt_d} = 3'b100;
                    state_d            = StDone;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IdxW'(1);
                end else begin
                    // Greater wins over less; anything else resolves to equal.
                    casez (cas_q)
                        3'b??1:  {lt_d, eq_d, gt_d} = 3'b001;
                        3'b1?0:  {lt_d, eq_d, gt_d} = 3'b100;
                        default: {lt_d, eq_d, gt_d} = 3'b010;
                    endcase
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StCmp);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cas_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cas_q   <= cas_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign lt_out = lt_q;
    assign eq_out = eq_q;
    assign gt_out = gt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: stimulus pushes expected result and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_seq_magnitude_comparator;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a, b;
    logic         lt_in, eq_in, gt_in;
    logic         busy, done, lt_out, eq_out, gt_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] res;   // {lt, eq, gt}
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .lt_in       (lt_in),
        .eq_in       (eq_in),
        .gt_in       (gt_in),
        .busy        (busy),
        .done        (done),
        .lt_out      (lt_out),
        .eq_out      (eq_out),
        .gt_out      (gt_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: whole-value integer compare; chunks examined = position of first differing chunk.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic sm, input logic [2:0] cas, input int k);
        exp_t   e;
        longint va, vb;
        logic [W-1:0] diff;
        int     m;
        va = sm ? longint'($signed(ia)) : longint'(ia);
        vb = sm ? longint'($signed(ib)) : longint'(ib);
        if (va > vb)      e.res = 3'b001;
        else if (va < vb) e.res = 3'b100;
        else if (cas[0])  e.res = 3'b001;
        else if (cas[2])  e.res = 3'b100;
        else              e.res = 3'b010;
        diff = ia ^ ib;
        m = N;
        for (int i = N - 1; i >= 0; i--) begin
            if (((diff >> (i * C)) & 16'hF) != 0) begin
                m = N - i;
                break;
            end
        end
        e.cyc = k + m;
        return e;
    endfunction

    // Drives a request; the next rising edge is the accept edge. cas = {lt_in, eq_in, gt_in}.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm,
                         input logic [2:0] cas);
        a = ia;
        b = ib;
        signed_mode = sm;
        {lt_in, eq_in, gt_in} = cas;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(model(ia, ib, sm, cas, cyc));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", int'({lt_out, eq_out, gt_out}), int'(e.res));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int nbusy;
        logic [W-1:0] ra, rb, mask;
        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        {lt_in, eq_in, gt_in} = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'({busy, done, lt_out, eq_out, gt_out}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full-length equal compare, then back-to-back signed compare from the done cycle
        issue(16'h1234, 16'h1234, 1'b0, 3'b010);
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) nbusy++;
        end
        chk("busy_cycles", nbusy, 4);
        chk("eq_at_done", int'({lt_out, eq_out, gt_out}), 3'b010);
        issue(16'h8000, 16'h7FFF, 1'b1, 3'b010);
        @(negedge clk);
        chk("b2b_hold", int'({done, busy, lt_out, eq_out, gt_out}), 5'b01010);
        wait_done();

        issue(16'hC000, 16'h4000, 1'b0, 3'b010);
        wait_done();
        issue(16'hC000, 16'h4000, 1'b1, 3'b010);
        wait_done();
        issue(16'h00FF, 16'h0100, 1'b0, 3'b010);
        wait_done();

        // Cascade fallback on equal operands
        issue(16'hABCD, 16'hABCD, 1'b0, 3'b101);
        wait_done();
        issue(16'hABCD, 16'hABCD, 1'b0, 3'b100);
        wait_done();
        issue(16'hABCD, 16'hABCD, 1'b0, 3'b000);
        wait_done();
        issue(16'hABCD, 16'hABCD, 1'b0, 3'b001);
        wait_done();

        // Start during CMP is ignored and operand changes do not leak in
        issue(16'h0001, 16'h0002, 1'b0, 3'b010);
        a = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        chk("ignored_start_lt", int'({lt_out, eq_out, gt_out}), 3'b100);

        // Reset two edges after accept aborts the compare
        @(negedge clk);
        issue(16'h1234, 16'h1234, 1'b0, 3'b010);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("abort_state", int'({busy, done, lt_out, eq_out, gt_out}), 0);
        repeat (8) @(negedge clk);

        // Randomized traffic with chunk-aligned partial matches and random gaps
        for (int t = 0; t < 150; t++) begin
            ra = W'($urandom);
            mask = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0) mask[i*C +: C] = C'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? W'($urandom) : (ra ^ mask);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
            issue(ra, rb, 1'($urandom), 3'($urandom));
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
